// File: rtl/mem_background_writer.sv
// Rectangular fill engine for the background BRAM: walks a screen-space region at
// half resolution, clips it to the memory bounds and emits one write per pixel.
module mem_background_writer #(
    parameter int MEM_W = 320,
    parameter int MEM_H = 170,
    parameter int Y_OFS = 30
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [9:0]  req_x,
    input  logic [9:0]  req_y,
    input  logic [3:0]  req_w,
    input  logic [3:0]  req_h,
    input  logic [11:0] req_color,
    output logic        mem_we,
    input  logic        mem_gnt,
    output logic [15:0] mem_waddr,
    output logic [11:0] mem_wdata,
    output logic        busy,
    output logic        done
);

    localparam int AW = 20;
    localparam logic [15:0] MW_BITS = 16'(MEM_W);

    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

    state_t                 state;
    logic [8:0]             x_r;
    logic [9:0]             y_r;
    logic [3:0]             w_r;
    logic [3:0]             h_r;
    logic [11:0]            color_r;
    logic [3:0]             cx;
    logic [3:0]             cy;
    logic signed [11:0]     my_cur;
    logic signed [AW-1:0]   row_base;

    logic                   accept;
    logic                   advance;
    logic                   last_col;
    logic                   last_pix;
    logic signed [10:0]     dy_s;
    logic signed [10:0]     my0_s;
    logic signed [11:0]     my0_e;
    logic signed [AW-1:0]   base0;
    logic                   ok0;
    logic [3:0]             nx;
    logic signed [11:0]     n_my;
    logic signed [AW-1:0]   n_base;
    logic signed [AW-1:0]   n_addr;
    logic                   n_ok;
    logic                   unused_x;

    // MEM_W * v built from shifted copies of v, one per set bit of MEM_W.
    function automatic logic signed [AW-1:0] mul_w(input logic signed [11:0] v);
        logic signed [AW-1:0] acc;
        logic signed [AW-1:0] ve;
        acc = '0;
        ve  = {{(AW-12){v[11]}}, v};
        for (int i = 0; i < 16; i++) begin
            if (MW_BITS[i]) acc = acc + (ve <<< i);
        end
        return acc;
    endfunction

    function automatic logic pix_ok(input logic [8:0] mx_base, input logic [3:0] col,
                                    input logic signed [11:0] my,
                                    input logic signed [AW-1:0] addr);
        int mx_i;
        int my_i;
        mx_i = int'(mx_base) + int'(col);
        my_i = int'(my);
        return (mx_i < MEM_W) && (my_i >= 0) && (my_i < MEM_H) &&
               !addr[AW-1] && (addr < AW'(MEM_W * MEM_H));
    endfunction

    assign req_ready = (state == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;
    assign unused_x  = req_x[0];

    // Origin mapping: arithmetic shift floors negative rows above the memory.
    assign dy_s  = $signed({1'b0, y_r}) - 11'(Y_OFS);
    assign my0_s = dy_s >>> 1;
    assign my0_e = {my0_s[10], my0_s};
    assign base0 = {{(AW-9){1'b0}}, x_r} + mul_w(my0_e);
    assign ok0   = pix_ok(x_r, 4'd0, my0_e, base0);

    assign advance  = (state == WRITE) && (!mem_we || mem_gnt);
    assign last_col = (cx == w_r);
    assign last_pix = last_col && (cy == h_r);
    assign nx       = last_col ? 4'd0 : cx + 4'd1;
    assign n_my     = last_col ? my_cur + 12'sd1 : my_cur;
    assign n_base   = last_col ? row_base + AW'(MEM_W) : row_base;
    assign n_addr   = n_base + {{(AW-4){1'b0}}, nx};
    assign n_ok     = pix_ok(x_r, nx, n_my, n_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_we    <= 1'b0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        state <= LOAD;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    state     <= WRITE;
                    mem_we    <= ok0;
                    mem_waddr <= ok0 ? base0[15:0] : '0;
                    mem_wdata <= ok0 ? color_r : '0;
                end
                WRITE: begin
                    if (advance) begin
                        if (last_pix) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            mem_we    <= 1'b0;
                            mem_waddr <= '0;
                            mem_wdata <= '0;
                        end else begin
                            mem_we    <= n_ok;
                            mem_waddr <= n_ok ? n_addr[15:0] : '0;
                            mem_wdata <= n_ok ? color_r : '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Request fields and the pixel cursor; only meaningful while busy.
    always_ff @(posedge clk) begin
        if (accept) begin
            x_r     <= req_x[9:1];
            y_r     <= req_y;
            w_r     <= req_w;
            h_r     <= req_h;
            color_r <= req_color;
        end
        if (state == LOAD) begin
            cx       <= 4'd0;
            cy       <= 4'd0;
            row_base <= base0;
            my_cur   <= my0_e;
        end else if (advance && !last_pix) begin
            cx <= nx;
            if (last_col) begin
                cy       <= cy + 4'd1;
                row_base <= n_base;
                my_cur   <= n_my;
            end
        end
    end

endmodule

// File: tb/tb_mem_background_writer.sv
// Bench for mem_background_writer: directed vector table, hand-written reset and
// held-request sequences, and randomized requests against a pixel-list model.
module tb_mem_background_writer;

    localparam int MEM_W = 320;
    localparam int MEM_H = 170;
    localparam int Y_OFS = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [9:0]  req_x = '0;
    logic [9:0]  req_y = '0;
    logic [3:0]  req_w = '0;
    logic [3:0]  req_h = '0;
    logic [11:0] req_color = '0;
    logic        mem_we;
    logic        mem_gnt = 1'b0;
    logic [15:0] mem_waddr;
    logic [11:0] mem_wdata;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;
    int exp_a[$];
    int p0_valid;

    typedef struct {
        int x; int y; int w; int h; int color;
        int gnt_mode; int hold;
        int exp_first; int exp_n;
    } vec_t;

    mem_background_writer #(.MEM_W(MEM_W), .MEM_H(MEM_H), .Y_OFS(Y_OFS)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
        .req_color(req_color), .mem_we(mem_we), .mem_gnt(mem_gnt),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Expected write list: every pixel of the region, row-major, kept if inside memory.
    task automatic model(input int x, input int y, input int w, input int h);
        int mx0;
        int my0;
        int mx;
        int my;
        exp_a.delete();
        mx0 = x / 2;
        my0 = (y - Y_OFS) >>> 1;
        p0_valid = (mx0 < MEM_W && my0 >= 0 && my0 < MEM_H) ? 1 : 0;
        for (int r = 0; r <= h; r++)
            for (int c = 0; c <= w; c++) begin
                mx = mx0 + c;
                my = my0 + r;
                if (mx < MEM_W && my >= 0 && my < MEM_H) exp_a.push_back(mx + MEM_W * my);
            end
    endtask

    task automatic do_req(input int x, input int y, input int w, input int h, input int col,
                          input int gnt_mode, input int hold,
                          output int nw, output int first);
        int cyc;
        int stalls;
        int held1;
        int stall_used;
        int npix;
        bit fin;
        bit prev_stall;
        logic [15:0] pa;
        logic [11:0] pd;
        model(x, y, w, h);
        npix = (w + 1) * (h + 1);
        nw = 0; first = -1; stalls = 0; held1 = 0; stall_used = 0;
        fin = 0; prev_stall = 0; pa = '0; pd = '0;
        @(negedge clk);
        req_valid = 1'b1;
        req_x = 10'(x); req_y = 10'(y); req_w = 4'(w); req_h = 4'(h); req_color = 12'(col);
        mem_gnt = 1'b1;
        #1 check("ready_idle", {31'b0, req_ready}, 1);
        @(negedge clk);
        #1;
        check("load_we", {31'b0, mem_we}, 0);
        check("load_busy", {31'b0, busy}, 1);
        check("load_ready", {31'b0, req_ready}, 0);
        if (hold != 0) begin
            req_x = 10'(x) ^ 10'h0AA; req_y = 10'(y) ^ 10'h055;
            req_w = 4'(w) ^ 4'h5; req_color = ~12'(col);
        end else begin
            req_valid = 1'b0;
        end
        cyc = 1;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            case (gnt_mode)
                0: mem_gnt = 1'b1;
                1: mem_gnt = 1'($urandom_range(0, 1));
                default: begin
                    if (nw == 1 && stall_used < 3) begin
                        mem_gnt = 1'b0;
                        stall_used++;
                    end else begin
                        mem_gnt = 1'b1;
                    end
                end
            endcase
            #1;
            check("ready_busy", {31'b0, req_ready}, 0);
            if (cyc == 2) check("first_we", {31'b0, mem_we}, 32'(p0_valid));
            if (prev_stall) begin
                check("hold_we", {31'b0, mem_we}, 1);
                check("hold_addr", {16'b0, mem_waddr}, {16'b0, pa});
                check("hold_data", {20'b0, mem_wdata}, {20'b0, pd});
            end
            if (mem_we) begin
                if (nw == 1) held1++;
                if (mem_gnt) begin
                    if (exp_a.size() == 0) begin
                        check("extra_write", {16'b0, mem_waddr}, 32'hFFFF_FFFF);
                    end else begin
                        check("waddr", {16'b0, mem_waddr}, 32'(exp_a.pop_front()));
                        check("wdata", {20'b0, mem_wdata}, 32'(col));
                    end
                    if (nw == 0) first = int'(mem_waddr);
                    nw++;
                end else begin
                    stalls++;
                end
            end else begin
                check("idle_addr", {16'b0, mem_waddr}, 0);
                check("idle_data", {20'b0, mem_wdata}, 0);
            end
            prev_stall = mem_we && !mem_gnt;
            pa = mem_waddr;
            pd = mem_wdata;
            if (done) fin = 1;
        end
        check("done_seen", {31'b0, fin}, 1);
        check("done_cycle", 32'(cyc), 32'(2 + npix + stalls));
        check("busy_in_done", {31'b0, busy}, 1);
        check("writes_left", 32'(exp_a.size()), 0);
        if (gnt_mode == 2) check("held_second", 32'(held1), 4);
        @(negedge clk);
        #1;
        check("done_pulse", {31'b0, done}, 0);
        check("busy_idle", {31'b0, busy}, 0);
        check("ready_after", {31'b0, req_ready}, 1);
        req_valid = 1'b0;
    endtask

    initial begin
        vec_t tab[8];
        int nw;
        int first;
        tab[0] = '{x:0,   y:30,  w:0,  h:0, color:'hF00, gnt_mode:0, hold:0, exp_first:0,     exp_n:1};
        tab[1] = '{x:100, y:50,  w:1,  h:1, color:'h0A5, gnt_mode:0, hold:0, exp_first:3250,  exp_n:4};
        tab[2] = '{x:636, y:368, w:3,  h:1, color:'h123, gnt_mode:0, hold:0, exp_first:54398, exp_n:2};
        tab[3] = '{x:100, y:50,  w:1,  h:1, color:'h3C3, gnt_mode:2, hold:0, exp_first:3250,  exp_n:4};
        tab[4] = '{x:10,  y:0,   w:2,  h:3, color:'hFFF, gnt_mode:0, hold:0, exp_first:-1,    exp_n:0};
        tab[5] = '{x:0,   y:28,  w:0,  h:2, color:'h800, gnt_mode:0, hold:0, exp_first:0,     exp_n:2};
        tab[6] = '{x:630, y:30,  w:15, h:0, color:'h00F, gnt_mode:0, hold:1, exp_first:315,   exp_n:5};
        tab[7] = '{x:2,   y:29,  w:0,  h:1, color:'h777, gnt_mode:1, hold:0, exp_first:1,     exp_n:1};

        #12;
        check("rst_we", {31'b0, mem_we}, 0);
        check("rst_addr", {16'b0, mem_waddr}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_ready", {31'b0, req_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ready_release", {31'b0, req_ready}, 1);

        for (int i = 0; i < 8; i++) begin
            do_req(tab[i].x, tab[i].y, tab[i].w, tab[i].h, tab[i].color,
                   tab[i].gnt_mode, tab[i].hold, nw, first);
            check($sformatf("vec%0d_count", i), 32'(nw), 32'(tab[i].exp_n));
            check($sformatf("vec%0d_first", i), 32'(first), 32'(tab[i].exp_first));
        end

        // Reset in the middle of a burst.
        @(negedge clk);
        req_valid = 1'b1; req_x = 10'd100; req_y = 10'd50; req_w = 4'd3; req_h = 4'd3;
        req_color = 12'hABC; mem_gnt = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #1 check("midburst_we", {31'b0, mem_we}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_we", {31'b0, mem_we}, 0);
        check("abort_addr", {16'b0, mem_waddr}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        check("abort_ready", {31'b0, req_ready}, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 check("abort_done", {31'b0, done}, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("abort_release_ready", {31'b0, req_ready}, 1);
        @(negedge clk);
        #1 check("abort_no_done", {31'b0, done}, 0);

        for (int i = 0; i < 40; i++) begin
            do_req(int'($urandom_range(0, 639)), int'($urandom_range(0, 420)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 4095)), int'($urandom_range(0, 1)), 0, nw, first);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_background_writer.md
MEM_BACKGROUND_WRITER -- requirements
Module: mem_background_writer

Interface
REQ-001 SHALL have parameter MEM_W, default 320, meaning background memory width in memory pixels.
REQ-002 SHALL have parameter MEM_H, default 170, meaning background memory height in memory pixels.
REQ-003 SHALL have parameter Y_OFS, default 30, meaning first screen row mapped to memory row 0.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  fill request present.
REQ-007 SHALL have port req_ready  output  1  block can accept a request.
REQ-008 SHALL have port req_x  input  10  screen x of region top-left (0..639).
REQ-009 SHALL have port req_y  input  10  screen y of region top-left.
REQ-010 SHALL have port req_w  input  4  region width minus 1, in memory pixels (1..16).
REQ-011 SHALL have port req_h  input  4  region height minus 1, in memory pixels (1..16).
REQ-012 SHALL have port req_color  input  12  RGB444 fill value.
REQ-013 SHALL have port mem_we  output  1  write strobe to background BRAM write port.
REQ-014 SHALL have port mem_gnt  input  1  write port granted; write completes only when mem_we and mem_gnt both high.
REQ-015 SHALL have port mem_waddr  output  16  write address.
REQ-016 SHALL have port mem_wdata  output  12  write data.
REQ-017 SHALL have port busy  output  1  request in progress.
REQ-018 SHALL have port done  output  1  one-cycle pulse after a request finishes.

Function
REQ-019 SHALL use the same mapping as the background read path: mx = x>>1, my = (y - Y_OFS)>>1 (arithmetic, signed 11-bit), addr = mx + MEM_W*my.
REQ-020 SHALL implement states IDLE, LOAD, WRITE, DONE; req_ready = 1 only in IDLE with rst_n high.
REQ-021 SHALL accept a request on a rising edge with req_valid & req_ready, latching x, y, w, h, color; IDLE->LOAD.
REQ-022 SHALL, in LOAD (one cycle, mem_we = 0), compute mx0, my0 and row base = mx0 + MEM_W*my0 using shift-add only (no multiplier); LOAD->WRITE.
REQ-023 SHALL visit (w+1)*(h+1) pixels in WRITE, row-major, column index incrementing first, one pixel per cycle when not stalled.
REQ-024 SHALL advance row address by adding MEM_W to the row base register, not by re-multiplying.
REQ-025 SHALL assert mem_we for a pixel only if 0 <= mx < MEM_W and 0 <= my < MEM_H; clipped pixels consume one cycle with mem_we = 0 and are never written.
REQ-026 SHALL, while mem_we = 1 and mem_gnt = 0, hold mem_we, mem_waddr and mem_wdata stable and not advance; clipped pixels do not wait for mem_gnt.
REQ-027 SHALL go WRITE->DONE after the last pixel completes; DONE asserts done = 1 for exactly one cycle, then DONE->IDLE.
REQ-028 SHALL ignore req_valid in LOAD, WRITE and DONE; requests are not queued.
REQ-029 SHALL hold busy = 1 in LOAD, WRITE and DONE; busy = 0 in IDLE.
REQ-030 SHALL drive mem_waddr, mem_wdata = 0 whenever mem_we = 0.
REQ-031 SHALL produce its first write in the second cycle after acceptance and no write addresses >= MEM_W*MEM_H (54400).

Reset
REQ-032 SHALL, while rst_n = 0, force state IDLE, mem_we = 0, mem_waddr = 0, mem_wdata = 0, busy = 0, done = 0, req_ready = 0, independent of clk.
REQ-033 SHALL abort any burst on reset assertion with no done pulse; req_ready = 1 on the first cycle after release.

Verification
REQ-034 SHALL pass: x=0, y=30, w=0, h=0, color=0xF00 -> one write addr 0 data 0xF00 two cycles after accept, done one cycle later.
REQ-035 SHALL pass: x=100, y=50, w=1, h=1, gnt=1 -> writes 3250, 3251, 3570, 3571 on consecutive cycles, then done.
REQ-036 SHALL pass: x=636, y=368, w=3, h=1 -> 8 WRITE cycles, writes only 54398, 54399; no address >= 54400.
REQ-037 SHALL pass: 2x2 request with mem_gnt low 3 cycles during second pixel -> addr 3251 held 4 cycles, each address written exactly once.
REQ-038 SHALL pass: rst_n low during WRITE -> mem_we = 0 immediately, no done, req_ready = 1 on first cycle after release.
REQ-039 SHALL pass: req_valid held high while busy with a second request -> not accepted until IDLE; first request's writes unaffected.
